// File: rtl/path_pkg.sv
// Shared definitions for the path replay block: direction codes, FSM
// encoding and the direction-to-step helper.
package path_pkg;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        PRESENT  = 3'd2,
        COMPLETE = 3'd3,
        WAIT_LOW = 3'd4
    } state_t;

    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
    } step_t;

    // Unit step for a direction code; north decreases y.
    function automatic step_t dir_step(input logic [1:0] dir);
        step_t s;
        s.dx = 2'sd0;
        s.dy = 2'sd0;
        case (dir)
            DIR_N:   s.dy = -2'sd1;
            DIR_E:   s.dx = 2'sd1;
            DIR_S:   s.dy = 2'sd1;
            default: s.dx = -2'sd1;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/path_list_ram.sv
// Move list storage: one write port, one synchronous read port.
// Ports:
//   CLK      clock
//   we       write enable
//   wr_addr  write address
//   wr_data  direction code to store
//   rd_addr  read address, sampled on CLK
//   rd_data  registered read data (one cycle latency)
module path_list_ram #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [1:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [1:0]    rd_data
);

    logic [1:0] mem [DEPTH];

    // Contents are intentionally not reset.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/path_player.sv
// Captures the solver's move list (pushed goal-first) and replays it
// start-to-goal as (x, y, dir) beats over a valid/ready handshake.
// Optional feature macro: BOUNDS_CHK_EN (adds sticky bounds_err and
// saturates coordinates at the maze edge instead of wrapping).
// Ports:
//   CLK, RST       clock, asynchronous active-high reset
//   init_list      synchronous clear of list, overflow and replay
//   list_push      append dir_in (only while IDLE)
//   dir_in         direction code being pushed
//   en_read        level request to replay the list
//   out_ready      downstream accepts the current beat
//   out_valid      beat valid
//   out_x, out_y   position after the move
//   out_dir        direction of the move
//   complete_read  one-cycle pulse when replay finishes
//   count          number of stored entries
//   bounds_err     (BOUNDS_CHK_EN only) sticky edge violation
//   overflow       sticky: a push was dropped on a full list
module path_player
    import path_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned AW      = 8,
    parameter int unsigned COORD_W = 4,
    parameter int unsigned START_X = 0,
    parameter int unsigned START_Y = 0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               init_list,
    input  logic               list_push,
    input  logic [1:0]         dir_in,
    input  logic               en_read,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic [1:0]         out_dir,
    output logic               complete_read,
    output logic [AW:0]        count,
`ifdef BOUNDS_CHK_EN
    output logic               bounds_err,
`endif
    output logic               overflow
);

    localparam int unsigned CW = AW + 1;

    state_t             state, state_d;
    logic [AW-1:0]      idx, idx_d;
    logic [AW:0]        count_d;
    logic               overflow_d;
    logic               out_valid_d;
    logic [COORD_W-1:0] out_x_d, out_y_d;
    logic [1:0]         out_dir_d;
    logic               complete_read_d;
    logic               we;
    logic [1:0]         rd_data;
    step_t              st;
    logic [COORD_W-1:0] nx, ny;
`ifdef BOUNDS_CHK_EN
    logic               oob;
    logic               bounds_err_d;
`endif

    // Read address follows the next index so data is ready during FETCH.
    path_list_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .CLK     (CLK),
        .we      (we),
        .wr_addr (count[AW-1:0]),
        .wr_data (dir_in),
        .rd_addr (idx_d),
        .rd_data (rd_data)
    );

    // Position after applying the fetched move to the current position.
    always_comb begin
        st = dir_step(rd_data);
        nx = out_x + COORD_W'(st.dx);
        ny = out_y + COORD_W'(st.dy);
`ifdef BOUNDS_CHK_EN
        oob = 1'b0;
        if ((st.dx == -2'sd1 && out_x == '0) || (st.dx == 2'sd1 && out_x == '1)) begin
            nx  = out_x;
            oob = 1'b1;
        end
        if ((st.dy == -2'sd1 && out_y == '0) || (st.dy == 2'sd1 && out_y == '1)) begin
            ny  = out_y;
            oob = 1'b1;
        end
`endif
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state;
        idx_d      = idx;
        count_d    = count;
        overflow_d = overflow;
        out_x_d    = out_x;
        out_y_d    = out_y;
        out_dir_d  = out_dir;
        we         = 1'b0;
`ifdef BOUNDS_CHK_EN
        bounds_err_d = bounds_err;
`endif

        case (state)
            IDLE: begin
                if (list_push) begin
                    if (count < CW'(DEPTH)) begin
                        we      = 1'b1;
                        count_d = count + CW'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if (en_read) begin
                    out_x_d = COORD_W'(START_X);
                    out_y_d = COORD_W'(START_Y);
`ifdef BOUNDS_CHK_EN
                    bounds_err_d = 1'b0;
`endif
                    if (count == '0) begin
                        state_d = COMPLETE;
                    end else begin
                        idx_d   = AW'(count - CW'(1));
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (!en_read) begin
                    state_d = IDLE;
                end else begin
                    // Position update happens once, on entry to PRESENT.
                    out_x_d   = nx;
                    out_y_d   = ny;
                    out_dir_d = rd_data;
`ifdef BOUNDS_CHK_EN
                    if (oob) begin
                        bounds_err_d = 1'b1;
                    end
`endif
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (!en_read) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    if (idx == '0) begin
                        state_d = COMPLETE;
                    end else begin
                        idx_d   = idx - AW'(1);
                        state_d = FETCH;
                    end
                end
            end
            COMPLETE: state_d = WAIT_LOW;
            WAIT_LOW: begin
                if (!en_read) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (init_list) begin
            state_d    = IDLE;
            count_d    = '0;
            overflow_d = 1'b0;
            we         = 1'b0;
        end

        out_valid_d     = (state_d == PRESENT);
        complete_read_d = (state_d == COMPLETE);
    end

    // State and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            idx           <= '0;
            count         <= '0;
            overflow      <= 1'b0;
            out_valid     <= 1'b0;
            out_x         <= COORD_W'(START_X);
            out_y         <= COORD_W'(START_Y);
            out_dir       <= 2'd0;
            complete_read <= 1'b0;
`ifdef BOUNDS_CHK_EN
            bounds_err    <= 1'b0;
`endif
        end else begin
            state         <= state_d;
            idx           <= idx_d;
            count         <= count_d;
            overflow      <= overflow_d;
            out_valid     <= out_valid_d;
            out_x         <= out_x_d;
            out_y         <= out_y_d;
            out_dir       <= out_dir_d;
            complete_read <= complete_read_d;
`ifdef BOUNDS_CHK_EN
            bounds_err    <= bounds_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_path_player.sv
// Self-checking bench for path_player: a model expands the pushed list into
// the expected beat sequence, which a monitor pops and compares on handshake.
module tb_path_player;

    localparam int unsigned DEPTH   = 256;
    localparam int unsigned AW      = 8;
    localparam int unsigned COORD_W = 4;
    localparam int unsigned START_X = 0;
    localparam int unsigned START_Y = 0;

    logic               CLK = 1'b0;
    logic               RST;
    logic               init_list, list_push, en_read, out_ready;
    logic [1:0]         dir_in;
    logic               out_valid, complete_read, overflow;
    logic [COORD_W-1:0] out_x, out_y;
    logic [1:0]         out_dir;
    logic [AW:0]        count;
`ifdef BOUNDS_CHK_EN
    logic               bounds_err;
`endif

    path_player #(
        .DEPTH(DEPTH), .AW(AW), .COORD_W(COORD_W), .START_X(START_X), .START_Y(START_Y)
    ) dut (
        .CLK(CLK), .RST(RST), .init_list(init_list), .list_push(list_push),
        .dir_in(dir_in), .en_read(en_read), .out_ready(out_ready),
        .out_valid(out_valid), .out_x(out_x), .out_y(out_y), .out_dir(out_dir),
        .complete_read(complete_read), .count(count),
`ifdef BOUNDS_CHK_EN
        .bounds_err(bounds_err),
`endif
        .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0] dir;
        logic [3:0] x;
        logic [3:0] y;
    } beat_t;

    int     n_vec = 0;
    int     n_err = 0;
    beat_t  exp_q[$];
    logic [1:0] list_q[$];
    int     holds[$];
    int     beat_cnt = 0, cr_cnt = 0, hold_len = 0;
    bit     any_valid = 0, stab_en = 1, prev_stall = 0, exp_berr = 0;
    beat_t  prev_beat, e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected beats: walk the list newest-first from the start cell.
    function automatic void load_expect();
        int x = int'(START_X);
        int y = int'(START_Y);
        exp_berr = 0;
        for (int i = list_q.size() - 1; i >= 0; i--) begin
            case (list_q[i])
                2'd0:    y = y - 1;
                2'd1:    x = x + 1;
                2'd2:    y = y + 1;
                default: x = x - 1;
            endcase
`ifdef BOUNDS_CHK_EN
            if (x < 0)  begin x = 0;  exp_berr = 1; end
            if (x > 15) begin x = 15; exp_berr = 1; end
            if (y < 0)  begin y = 0;  exp_berr = 1; end
            if (y > 15) begin y = 15; exp_berr = 1; end
`else
            x = x & 15;
            y = y & 15;
`endif
            exp_q.push_back('{dir: list_q[i], x: 4'(x), y: 4'(y)});
        end
    endfunction

    // Monitor: scoreboard pop on handshake, stall stability, event counts.
    always @(negedge CLK) begin
        if (RST) begin
            prev_stall = 0;
            hold_len   = 0;
        end else begin
            if (out_valid) any_valid = 1;
            if (complete_read) cr_cnt++;
            if (stab_en && prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", 32'({out_dir, out_x, out_y}), 32'(prev_beat));
            end
            if (out_valid) hold_len++;
            if (out_valid && out_ready) begin
                check("beat_avail", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("beat_dir", 32'(out_dir), 32'(e.dir));
                    check("beat_x", 32'(out_x), 32'(e.x));
                    check("beat_y", 32'(out_y), 32'(e.y));
                end
                beat_cnt++;
                holds.push_back(hold_len);
                hold_len = 0;
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = {out_dir, out_x, out_y};
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_dir(input logic [1:0] d);
        list_push = 1'b1;
        dir_in    = d;
        tick();
        list_push = 1'b0;
        if (list_q.size() < DEPTH) list_q.push_back(d);
    endtask

    task automatic do_init();
        init_list = 1'b1;
        tick();
        init_list = 1'b0;
        list_q.delete();
    endtask

    // Raise en_read, wait for complete_read, verify one pulse and no re-replay.
    task automatic run_replay(input string tag, input int budget, output int lv, output int lc);
        int c0, b0, nb;
        c0 = cr_cnt;
        b0 = beat_cnt;
        nb = list_q.size();
        lv = 0;
        lc = 0;
        en_read = 1'b1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge CLK);
            if (out_valid && lv == 0) lv = i;
            if (complete_read) begin
                lc = i;
                break;
            end
        end
        check({tag, "_done"}, 32'(lc != 0), 32'd1);
        repeat (5) tick();
        check({tag, "_cr_once"}, 32'(cr_cnt - c0), 32'd1);
        check({tag, "_beats"}, 32'(beat_cnt - b0), 32'(nb));
        check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
        en_read = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lv, lc, b0, c0, seen;
        RST = 1'b1; init_list = 1'b0; list_push = 1'b0; dir_in = 2'd0;
        en_read = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_x", 32'(out_x), 32'(START_X));
        check("rst_y", 32'(out_y), 32'(START_Y));
        check("rst_dir", 32'(out_dir), 32'd0);
        check("rst_cr", 32'(complete_read), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        RST = 1'b0;
        tick();

        // Basic replay of 1,1,2 with ready held high.
        push_dir(2'd1); push_dir(2'd1); push_dir(2'd2);
        check("count3", 32'(count), 32'd3);
        load_expect();
        out_ready = 1'b1;
        run_replay("basic", 40, lv, lc);
        check("first_valid_lat", 32'(lv), 32'd3);

        // Same list, second beat stalled for five cycles.
        load_expect();
        b0 = beat_cnt;
        fork
            run_replay("stall", 60, lv, lc);
            begin
                out_ready = 1'b1;
                seen = 0;
                for (int i = 0; i < 20 && seen == 0; i++) begin
                    @(negedge CLK);
                    if (out_valid && out_ready) seen = 1;
                end
                @(posedge CLK); #1;
                out_ready = 1'b0;
                seen = 0;
                for (int i = 0; i < 20 && seen == 0; i++) begin
                    @(negedge CLK);
                    if (out_valid) seen = 1;
                end
                repeat (5) @(posedge CLK);
                #1;
                out_ready = 1'b1;
            end
        join
        check("stall_len", 32'(holds.size() > b0 + 1 ? holds[b0 + 1] : 0), 32'd6);

        // Empty list: immediate completion, no beats.
        do_init();
        check("empty_count", 32'(count), 32'd0);
        exp_q.delete();
        any_valid = 0;
        run_replay("empty", 20, lv, lc);
        check("empty_cr_lat", 32'(lc), 32'd2);
        check("empty_no_valid", 32'(any_valid), 32'd0);

        // Fill past capacity, replay the full list, then clear.
        for (int i = 0; i < DEPTH + 3; i++) push_dir(2'($urandom_range(0, 3)));
        check("full_count", 32'(count), 32'(DEPTH));
        check("full_ovf", 32'(overflow), 32'd1);
        load_expect();
        run_replay("full", 2000, lv, lc);
        do_init();
        check("init_count", 32'(count), 32'd0);
        check("init_ovf", 32'(overflow), 32'd0);

        // Abort during the second beat, then a complete replay from start.
        push_dir(2'd1); push_dir(2'd1); push_dir(2'd2);
        exp_q.delete();
        load_expect();
        stab_en = 0;
        c0 = cr_cnt;
        out_ready = 1'b1;
        en_read = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge CLK);
            if (out_valid && out_ready) seen = 1;
        end
        @(posedge CLK); #1;
        out_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge CLK);
            if (out_valid) seen = 1;
        end
        check("abort_reach_beat2", 32'(seen), 32'd1);
        @(posedge CLK); #1;
        en_read = 1'b0;
        tick();
        @(negedge CLK);
        check("abort_valid", 32'(out_valid), 32'd0);
        repeat (4) tick();
        check("abort_no_cr", 32'(cr_cnt - c0), 32'd0);
        check("abort_count", 32'(count), 32'd3);
        exp_q.delete();
        load_expect();
        stab_en = 1;
        out_ready = 1'b1;
        run_replay("rereplay", 40, lv, lc);

        // Asynchronous reset in the middle of a stalled beat.
        exp_q.delete();
        load_expect();
        stab_en = 0;
        out_ready = 1'b0;
        en_read = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge CLK);
            if (out_valid) seen = 1;
        end
        RST = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_x", 32'(out_x), 32'(START_X));
        check("mid_rst_y", 32'(out_y), 32'(START_Y));
        check("mid_rst_dir", 32'(out_dir), 32'd0);
        check("mid_rst_cr", 32'(complete_read), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        en_read = 1'b0;
        tick();
        RST = 1'b0;
        tick();
        exp_q.delete();
        list_q.delete();
        stab_en = 1;

        // Single west move from the start corner.
        out_ready = 1'b1;
        push_dir(2'd3);
        load_expect();
        run_replay("wrap", 20, lv, lc);
`ifdef BOUNDS_CHK_EN
        check("wrap_x", 32'(out_x), 32'd0);
        check("bounds_set", 32'(bounds_err), 32'(exp_berr));
        do_init();
        push_dir(2'd1);
        load_expect();
        run_replay("bounds_clr", 20, lv, lc);
        check("bounds_clr", 32'(bounds_err), 32'(exp_berr));
`else
        check("wrap_x", 32'(out_x), 32'd15);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
